// File: rtl/sr_univ_pkg.sv
// Shared types and the mode-application helper for the universal shift register.
package sr_univ_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROL  = 3'd4,
    MODE_ROR  = 3'd5,
    MODE_ASR  = 3'd6,
    MODE_RSVD = 3'd7
  } mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Operates on a MAX_W container; only the low `width` bits are meaningful.
  function automatic logic [MAX_W-1:0] apply_mode(
    input mode_t             m,
    input logic [MAX_W-1:0]  q,
    input logic [MAX_W-1:0]  ld,
    input logic              sl,
    input logic              sr,
    input int unsigned       width
  );
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] msb;
    logic [MAX_W-1:0] r;
    logic             top;
    mask = {MAX_W{1'b1}} >> (MAX_W - width);
    msb  = {{(MAX_W-1){1'b0}}, 1'b1} << (width - 1);
    top  = |(q & msb);
    case (m)
      MODE_LOAD: r = ld;
      MODE_SHL:  r = (q << 1) | {{(MAX_W-1){1'b0}}, sl};
      MODE_SHR:  r = (q >> 1) | (sr ? msb : '0);
      MODE_ROL:  r = (q << 1) | {{(MAX_W-1){1'b0}}, top};
      MODE_ROR:  r = (q >> 1) | (q[0] ? msb : '0);
      MODE_ASR:  r = (q >> 1) | (top ? msb : '0);
      default:   r = q;
    endcase
    return r & mask;
  endfunction

endpackage

// File: rtl/sr_univ_burst_ctrl.sv
// Burst FSM: latches mode/length on start, issues one step per cycle, busy/done handshake.
module sr_univ_burst_ctrl
  import sr_univ_pkg::*;
#(
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         i_mode,
  input  logic               i_shift_en,
  input  logic               i_start,
  input  logic [BURST_W-1:0] i_burst_len,
  output logic [2:0]         o_eff_mode,
  output logic               o_step,
  output logic               o_busy,
  output logic               o_done
);

  state_t             r_state;
  mode_t              r_mode;
  logic [BURST_W-1:0] r_cnt;
  logic               w_accept;

  assign w_accept = (r_state == ST_IDLE) && i_start &&
                    (i_mode >= MODE_SHL) && (i_mode <= MODE_ASR);

  always_comb begin
    o_eff_mode = i_mode;
    o_step     = 1'b0;
    if (r_state == ST_BURST) begin
      o_eff_mode = r_mode;
      o_step     = 1'b1;
    end else begin
      o_step = i_shift_en && !w_accept;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_HOLD;
      r_cnt   <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mode <= mode_t'(i_mode);
            if (i_burst_len != '0) begin
              r_cnt   <= i_burst_len;
              r_state <= ST_BURST;
              o_busy  <= 1'b1;
            end else begin
              o_done <= 1'b1;
            end
          end
        end
        ST_BURST: begin
          if (r_cnt == BURST_W'(1)) begin
            r_state <= ST_IDLE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
          end
          r_cnt <= r_cnt - BURST_W'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sr_univ.sv
// Universal shift register with burst engine. Optional parity output: define SR_UNIV_PARITY_EN.
module sr_univ
  import sr_univ_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         mode,
  input  logic               shift_en,
  input  logic               sin_l,
  input  logic               sin_r,
  input  logic [WIDTH-1:0]   load_data,
  input  logic               start,
  input  logic [BURST_W-1:0] burst_len,
  output logic [WIDTH-1:0]   Q,
  output logic               sout_l,
  output logic               sout_r,
  output logic               busy,
  output logic               done,
  output logic               q_parity
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;
  logic [2:0]       w_eff_mode;
  logic             w_step;

  sr_univ_burst_ctrl #(.BURST_W(BURST_W)) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .i_mode      (mode),
    .i_shift_en  (shift_en),
    .i_start     (start),
    .i_burst_len (burst_len),
    .o_eff_mode  (w_eff_mode),
    .o_step      (w_step),
    .o_busy      (busy),
    .o_done      (done)
  );

  assign w_next = WIDTH'(apply_mode(mode_t'(w_eff_mode), MAX_W'(r_q), MAX_W'(load_data),
                                    sin_l, sin_r, WIDTH));

  always_ff @(posedge clk) begin
    if (reset)       r_q <= '0;
    else if (w_step) r_q <= w_next;
  end

  assign Q      = r_q;
  assign sout_l = r_q[WIDTH-1];
  assign sout_r = r_q[0];

`ifdef SR_UNIV_PARITY_EN
  assign q_parity = ^r_q;
`else
  assign q_parity = 1'b0;
`endif

endmodule

// File: tb/tb_sr_univ.sv
// Self-checking bench for sr_univ: directed literal checks plus randomized traffic vs. a queue-based model.
module tb_sr_univ;
  import sr_univ_pkg::*;

  localparam int W  = 8;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    mode = 3'd0;
  logic          shift_en = 1'b0;
  logic          sin_l = 1'b0;
  logic          sin_r = 1'b0;
  logic [W-1:0]  load_data = '0;
  logic          start = 1'b0;
  logic [BW-1:0] burst_len = '0;
  logic [W-1:0]  Q;
  logic          sout_l, sout_r, busy, done, q_parity;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  sr_univ #(.WIDTH(W), .BURST_W(BW)) dut (
    .clk(clk), .reset(reset), .mode(mode), .shift_en(shift_en),
    .sin_l(sin_l), .sin_r(sin_r), .load_data(load_data), .start(start),
    .burst_len(burst_len), .Q(Q), .sout_l(sout_l), .sout_r(sout_r),
    .busy(busy), .done(done), .q_parity(q_parity)
  );

  always #5 clk = ~clk;

  // Reference model: arithmetic on integers, burst as a queue of pending ops.
  longint unsigned m_q = 0;
  int              m_ops[$];
  bit              m_done = 1'b0;

  function automatic longint unsigned op(int m, longint unsigned q, longint unsigned ld,
                                         bit sl, bit sr);
    longint unsigned M = longint'(1) << W;
    longint unsigned H = longint'(1) << (W - 1);
    case (m)
      1: return ld;
      2: return (q * 2 + sl) % M;
      3: return q / 2 + (sr ? H : 0);
      4: return (q * 2) % M + q / H;
      5: return q / 2 + (q % 2) * H;
      6: return q / 2 + ((q >= H) ? H : 0);
      default: return q;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_q = 0;
      m_ops.delete();
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_ops.size() > 0) begin
        m_q = op(m_ops.pop_front(), m_q, load_data, sin_l, sin_r);
        if (m_ops.size() == 0) m_done = 1'b1;
      end else if (start && mode >= 2 && mode <= 6) begin
        if (burst_len == 0) m_done = 1'b1;
        else for (int i = 0; i < int'(burst_len); i++) m_ops.push_back(int'(mode));
      end else if (shift_en) begin
        m_q = op(int'(mode), m_q, load_data, sin_l, sin_r);
      end
    end
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      longint unsigned exp_par;
`ifdef SR_UNIV_PARITY_EN
      exp_par = ^m_q[W-1:0];
`else
      exp_par = 0;
`endif
      chk("model_Q", Q, m_q);
      chk("model_sout_l", sout_l, m_q[W-1]);
      chk("model_sout_r", sout_r, m_q[0]);
      chk("model_busy", busy, (m_ops.size() > 0) ? 1 : 0);
      chk("model_done", done, m_done);
      chk("model_parity", q_parity, exp_par);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input logic [2:0] m, input logic [W-1:0] ld);
    mode = m; load_data = ld; shift_en = 1'b1; start = 1'b0;
    tick();
    shift_en = 1'b0;
  endtask

  initial begin
    // 1: reset held while trying to load
    mode = MODE_LOAD; shift_en = 1'b1; load_data = 8'hFF; reset = 1'b1;
    check_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_Q", Q, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
    reset = 1'b0; shift_en = 1'b0;

    // 2: load / SHL / ASR / SHR
    single(MODE_LOAD, 8'hA5);   chk("load_A5", Q, 8'hA5);
    sin_l = 1'b1; single(MODE_SHL, 8'h00); chk("shl", Q, 8'h4B);
    single(MODE_ASR, 8'h00);    chk("asr", Q, 8'h25);
    sin_r = 1'b1; single(MODE_SHR, 8'h00); chk("shr", Q, 8'h92);
    sin_l = 1'b0; sin_r = 1'b0;

    // 3: ROR and idle hold
    single(MODE_LOAD, 8'h81);
    single(MODE_ROR, 8'h00);
    chk("ror", Q, 8'hC0); chk("ror_sout_r", sout_r, 0); chk("ror_sout_l", sout_l, 1);
    mode = MODE_ROR; tick(); chk("hold", Q, 8'hC0);

    // 4: ROL burst of 3, live mode toggled mid-burst
    single(MODE_LOAD, 8'h96);
    mode = MODE_ROL; burst_len = 4'd3; start = 1'b1; tick();
    chk("b_accept_Q", Q, 8'h96); chk("b_accept_busy", busy, 1);
    start = 1'b0; mode = MODE_LOAD; shift_en = 1'b1; load_data = 8'h11;
    tick(); chk("b_op1", Q, 8'h2D); chk("b_busy1", busy, 1); chk("b_done1", done, 0);
    tick(); chk("b_op2", Q, 8'h5A); chk("b_busy2", busy, 1);
    tick(); chk("b_op3", Q, 8'hB4); chk("b_busy3", busy, 0); chk("b_done3", done, 1);
    shift_en = 1'b0;
    tick(); chk("b_done_off", done, 0); chk("b_after", Q, 8'hB4);

    // 5: SHL burst aborted by reset
    single(MODE_LOAD, 8'h0F);
    mode = MODE_SHL; sin_l = 1'b1; burst_len = 4'd5; start = 1'b1; tick();
    start = 1'b0; tick(); tick();
    chk("abort_mid", Q, 8'h3F);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("abort_Q", Q, 8'h00); chk("abort_busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      tick(); chk("abort_no_done", done, 0);
    end
    sin_l = 1'b0;

    // 6: zero-length burst, ignored LOAD start, parity
    single(MODE_LOAD, 8'h3C);
    mode = MODE_SHR; burst_len = 4'd0; start = 1'b1; tick(); start = 1'b0;
    chk("z_Q", Q, 8'h3C); chk("z_busy", busy, 0); chk("z_done", done, 1);
    tick(); chk("z_done_off", done, 0);
    mode = MODE_LOAD; load_data = 8'h07; shift_en = 1'b1; start = 1'b1; burst_len = 4'd4;
    tick(); start = 1'b0; shift_en = 1'b0;
    chk("ld_start_Q", Q, 8'h07); chk("ld_start_busy", busy, 0);
`ifdef SR_UNIV_PARITY_EN
    chk("parity_07", q_parity, 1);
`else
    chk("parity_off", q_parity, 0);
`endif

    // Back-to-back: new start in the done cycle
    mode = MODE_ROR; burst_len = 4'd1; start = 1'b1; tick();
    tick(); chk("bb_done", done, 1); chk("bb_Q", Q, 8'h83);
    mode = MODE_ROL; start = 1'b1; tick(); start = 1'b0;
    chk("bb_busy", busy, 1);
    tick(); chk("bb_Q2", Q, 8'h07); chk("bb_done2", done, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      mode      = 3'($urandom_range(0, 7));
      shift_en  = 1'($urandom);
      sin_l     = 1'($urandom);
      sin_r     = 1'($urandom);
      load_data = W'($urandom);
      start     = ($urandom_range(0, 5) == 0);
      burst_len = BW'($urandom);
      tick();
    end
    reset = 1'b0; start = 1'b0; shift_en = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sr_univ.md
Name: sr_univ

Overview:
- Parametrised universal shift register, successor to the fixed 4-bit left-shift register.
- Supports parallel load, logical and arithmetic shifts, rotates, serial in and out at both ends.
- Adds a burst engine: one start pulse performs N back-to-back shift or rotate operations, with busy/done handshake.
- Used as a generic serializer/deserializer and data-alignment stage in the datapath.

Parameters:
- WIDTH, 8, register width in bits (≥2).
- BURST_W, 4, width of the burst_len field. Maximum burst is 2^BURST_W-1 operations.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- mode  input  3  operation select. Encodings are in sr_univ_pkg.
- shift_en  input  1  single-step enable, honoured in IDLE only.
- sin_l  input  1  serial input entering Q[0] on a left shift.
- sin_r  input  1  serial input entering Q[WIDTH-1] on a logical right shift.
- load_data  input  WIDTH  parallel load value.
- start  input  1  burst request pulse.
- burst_len  input  BURST_W  number of operations in the burst.
- Q  output  WIDTH  register contents.
- sout_l  output  1  Q[WIDTH-1], combinational from Q.
- sout_r  output  1  Q[0], combinational from Q.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse at burst completion.
- q_parity  output  1  parity of Q; see Optional Feature.

Behaviour:
- Mode encodings:
  - 0 HOLD
  - 1 LOAD: Q <= load_data
  - 2 SHL: Q <= {Q[WIDTH-2:0], sin_l}
  - 3 SHR: Q <= {sin_r, Q[WIDTH-1:1]}
  - 4 ROL
  - 5 ROR
  - 6 ASR: MSB replicated
  - 7 reserved, behaves as HOLD
- Reset: on any clk edge with reset=1, Q=0, busy=0, done=0, FSM=IDLE. Reset overrides all other inputs and aborts any burst with no done pulse.
- FSM states are IDLE and BURST.
- IDLE:
  - If start=1 and mode is in 2..6, the burst is accepted at that edge and no shift occurs on it. mode and burst_len are latched.
    - If burst_len≠0: go to BURST with busy=1.
    - If burst_len=0: stay IDLE, done=1 for the next cycle, Q unchanged.
  - If start=1 and mode is in {0,1,7}, start is ignored and single-step rules apply.
  - Otherwise, if shift_en=1, one operation selected by mode executes at the edge. If shift_en=0, Q holds.
- BURST:
  - Each edge executes the latched mode once; the counter decrements.
  - Live mode, shift_en, start and load_data are ignored. sin_l and sin_r are sampled live each cycle.
  - On the edge executing operation N: return to IDLE, busy=0, done=1 for exactly one cycle.
- Latency: for a burst accepted at edge k, operations occur at edges k+1..k+N. busy is high after edges k..k+N-1 and done is high after edge k+N.
- A start arriving in the done cycle is accepted normally, enabling back-to-back bursts.
- Single-step latency is one edge. sout_l and sout_r have zero latency from Q.

Optional Feature:
- Macro: SR_UNIV_PARITY_EN.
- Defined: q_parity is the XOR-reduction of Q, combinational, valid whenever Q is valid, including 0 after reset.
- Undefined: q_parity is tied to 0 and no parity logic is generated. The port list is identical in both builds.

Decomposition:
- Package sr_univ_pkg holds:
  - the 3-bit mode typedef and the eight named mode constants;
  - the FSM state typedef;
  - a helper function that applies a mode to a vector, using WIDTH as an argument.
- Sub-module sr_univ_burst_ctrl holds the FSM, the burst counter, the latched mode, and the busy/done logic. It outputs the effective mode and a step enable to the datapath.
- The datapath remains in sr_univ.

Test Plan (WIDTH=8):
1. Hold reset for 2 cycles while driving shift_en=1, mode=LOAD, load_data=FF → Q=00, busy=0, done=0 throughout reset.
2. LOAD A5, then one SHL step with sin_l=1 → Q=4B; then one ASR step → Q=25; then SHR with sin_r=1 → Q=92.
3. LOAD 81, one ROR step → Q=C0, sout_r=0, sout_l=1; step with shift_en=0 → Q stays C0.
4. LOAD 96, start with mode=ROL, burst_len=3, at edge 0 → Q=2D, 5A, B4 after edges 1, 2, 3. busy is high for 3 cycles. done is high for exactly the cycle after edge 3. mode toggled to LOAD mid-burst has no effect.
5. Start a SHL burst with burst_len=5 and assert reset in the cycle after the 2nd operation → Q=00, busy=0 at the next edge, and done never pulses.
6. Start with burst_len=0 → done pulses once, busy stays 0, Q unchanged. Start with mode=LOAD → ignored as a burst and Q loads via shift_en. With SR_UNIV_PARITY_EN defined, Q=07 gives q_parity=1; without the macro, q_parity=0.
